uart_rx_frame_check: RTL and testbench
======================================

Name: uart_rx_frame_check

Overview:
- Parametrised UART receive frame checker.
- Sits between the RX start-bit detector / oversampling tick generator and the RX FIFO.
- After a validated start bit, it samples data, parity and stop bits on RX_tick using its own bit counter.
- Outputs the assembled word with per-frame parity, stop and break status, plus sticky status flags and saturating error counters for the register block.

Parameters:
DATA_W, 8, data bits per frame, legal 5..9
CNT_W, 8, width of each saturating error counter, legal 1..16

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
CFG_PAR_EN  in  1  parity bit present in frame
CFG_PAR_MODE  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
CFG_STOP2  in  1  0 = one stop bit, 1 = two stop bits
START  in  1  one-cycle pulse: start bit validated
RX_tick  in  1  one-cycle pulse at bit centre
SER_DATA  in  1  synchronised serial line
STS_CLR  in  1  clears sticky flags and counters
DATA_OUT  out  DATA_W  received word, LSB first on line
FRAME_VALID  out  1  one-cycle pulse, frame result valid
PARITY_ERROR  out  1  per-frame parity mismatch
STOP_ERROR  out  1  per-frame stop-bit error
BREAK_DET  out  1  per-frame break condition
STICKY_PAR  out  1  sticky parity error
STICKY_STOP  out  1  sticky stop error
STICKY_BRK  out  1  sticky break
PAR_ERR_CNT  out  CNT_W  saturating parity-error count
STOP_ERR_CNT  out  CNT_W  saturating stop-error count
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST low, async): FSM to IDLE; every output and internal register 0.
- Reset mid-frame discards the partial frame; no FRAME_VALID is produced.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE:
  - START=1 latches CFG_* into shadow registers, clears the bit counter and goes to DATA.
  - An RX_tick in the same cycle as START is ignored.
  - START outside IDLE is ignored.
- DATA: each RX_tick shifts SER_DATA in LSB first. After DATA_W ticks, go to PARITY if shadow PAR_EN=1, else STOP1.
- PARITY: on RX_tick, sample the parity bit.
  - Expected value: even = ^data, odd = ~^data, mark = 1, space = 0.
  - Mismatch sets the pending parity error.
  - Then go to STOP1.
- STOP1: on RX_tick, SER_DATA=0 sets the pending stop error. Go to STOP2 if shadow STOP2=1, else DONE.
- STOP2: on RX_tick, SER_DATA=0 sets the pending stop error. Go to DONE.
- Break: data all 0, parity bit 0 (when present) and STOP1 sample 0 → pending break=1. STOP_ERROR is also 1 for that frame.
- Result timing:
  - On the edge that moves the FSM into DONE, DATA_OUT, PARITY_ERROR, STOP_ERROR and BREAK_DET are registered.
  - FRAME_VALID is high for exactly the DONE cycle; DONE → IDLE on the next edge.
  - DATA_OUT and the per-frame flags hold until the next FRAME_VALID.
  - Latency from the final stop-bit tick to FRAME_VALID: 1 cycle.
- START in the DONE cycle is ignored.
- Sticky flags: set on FRAME_VALID when the matching per-frame flag is 1; cleared by STS_CLR. Set and clear in the same cycle → set wins (flag = 1).
- Counters:
  - PAR_ERR_CNT increments on FRAME_VALID with PARITY_ERROR.
  - STOP_ERR_CNT increments on FRAME_VALID with STOP_ERROR and not BREAK_DET.
  - Both saturate at 2^CNT_W-1.
  - STS_CLR sets a counter to 0, or to 1 if an increment occurs in the same cycle.
- CFG_* changes mid-frame have no effect until the next START.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE.
  - FSM state enum for this block.
- Natural sub-module: uart_sat_counter (CNT_W-wide saturating counter with clear and increment, clear+increment = 1), instantiated twice.

Test Plan:
- 8N1, DATA_W=8, frame 0xA5, stop=1 → FRAME_VALID 1 cycle after the stop tick, DATA_OUT=0xA5, all error flags 0, counters 0.
- 8E1, data 0x07, parity bit 0 (expected 1) → PARITY_ERROR=1, STICKY_PAR=1, PAR_ERR_CNT=1, STOP_ERROR=0.
- DATA_W=7, odd parity, STOP2=1, data 0x55, correct parity, STOP1=1, STOP2=0 → STOP_ERROR=1, STOP_ERR_CNT=1, BREAK_DET=0.
- 8E1 with line held 0 for the entire frame → BREAK_DET=1, STOP_ERROR=1, STICKY_BRK=1, STOP_ERR_CNT unchanged at 0.
- CNT_W=2, five parity-error frames → PAR_ERR_CNT=3. Then STS_CLR coincident with a sixth error frame's FRAME_VALID → STICKY_PAR=1, PAR_ERR_CNT=1.
- RST low during DATA after 3 ticks, release, then a clean 8N1 0x3C frame → no FRAME_VALID for the aborted frame; second frame gives DATA_OUT=0x3C with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: parity-mode encodings, the receive
//                frame-checker state enum and an expected-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Parity-mode encodings carried on CFG_PAR_MODE.
  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Frame-checker FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  // Value the parity bit must carry, given the mode and the XOR of the data.
  function automatic logic par_expected(input logic [1:0] mode, input logic data_xor);
    logic v;
    case (mode)
      PAR_EVEN:  v = data_xor;
      PAR_ODD:   v = ~data_xor;
      PAR_MARK:  v = 1'b1;
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sat_counter
//  Description : CNT_W-wide saturating event counter. A clear coincident with
//                an increment loads 1 so the event is not lost.
//  Ports       : CLK, RST (async active-low), clr, inc, count[CNT_W-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= inc ? C_ONE : '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule : uart_sat_counter
`default_nettype wire

// File: rtl/uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_check
//  Description : UART receive frame checker. After a validated start bit it
//                samples data, optional parity and one/two stop bits on
//                RX_tick, then presents the word with per-frame parity, stop
//                and break status, sticky flags and saturating error counts.
//  Ports       : CLK, RST (async active-low)
//                CFG_PAR_EN, CFG_PAR_MODE[1:0], CFG_STOP2  - frame format
//                START, RX_tick, SER_DATA                  - line interface
//                STS_CLR                                   - status clear
//                DATA_OUT[DATA_W-1:0], FRAME_VALID, PARITY_ERROR,
//                STOP_ERROR, BREAK_DET                     - per-frame result
//                STICKY_PAR/STOP/BRK, PAR_ERR_CNT, STOP_ERR_CNT, BUSY
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_PAR_EN,
  input  logic [1:0]        CFG_PAR_MODE,
  input  logic              CFG_STOP2,
  input  logic              START,
  input  logic              RX_tick,
  input  logic              SER_DATA,
  input  logic              STS_CLR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              FRAME_VALID,
  output logic              PARITY_ERROR,
  output logic              STOP_ERROR,
  output logic              BREAK_DET,
  output logic              STICKY_PAR,
  output logic              STICKY_STOP,
  output logic              STICKY_BRK,
  output logic [CNT_W-1:0]  PAR_ERR_CNT,
  output logic [CNT_W-1:0]  STOP_ERR_CNT,
  output logic              BUSY
);

  localparam int             BC_W       = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] C_LAST_BIT = BC_W'(DATA_W - 1);

  rx_state_e         r_state, w_next;
  logic              r_par_en, r_stop2;
  logic [1:0]        r_par_mode;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bit, r_pend_par, r_pend_stop, r_pend_brk;
  logic [DATA_W-1:0] r_data_out;
  logic              r_par_err, r_stop_err, r_brk;
  logic              r_sticky_par, r_sticky_stop, r_sticky_brk;
  logic              w_brk_now, w_enter_done, w_fv;

  // Break needs every sampled bit low up to and including the first stop bit.
  assign w_brk_now    = (r_shift == '0) && (!r_par_en || !r_par_bit) && !SER_DATA;
  assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
  assign w_fv         = (r_state == ST_DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (START) w_next = ST_DATA;
      ST_DATA:   if (RX_tick && (r_bit_cnt == C_LAST_BIT))
                   w_next = r_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (RX_tick) w_next = ST_STOP1;
      ST_STOP1:  if (RX_tick) w_next = r_stop2 ? ST_STOP2 : ST_DONE;
      ST_STOP2:  if (RX_tick) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- sampling
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en    <= 1'b0;
      r_par_mode  <= 2'b00;
      r_stop2     <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_pend_par  <= 1'b0;
      r_pend_stop <= 1'b0;
      r_pend_brk  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (START) begin
          // Format is frozen for the whole frame at the start bit.
          r_par_en    <= CFG_PAR_EN;
          r_par_mode  <= CFG_PAR_MODE;
          r_stop2     <= CFG_STOP2;
          r_bit_cnt   <= '0;
          r_par_bit   <= 1'b0;
          r_pend_par  <= 1'b0;
          r_pend_stop <= 1'b0;
          r_pend_brk  <= 1'b0;
        end
        ST_DATA: if (RX_tick) begin
          // LSB arrives first, so shift in from the top.
          r_shift   <= {SER_DATA, r_shift[DATA_W-1:1]};
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
        end
        ST_PARITY: if (RX_tick) begin
          r_par_bit  <= SER_DATA;
          r_pend_par <= (SER_DATA != par_expected(r_par_mode, ^r_shift));
        end
        ST_STOP1: if (RX_tick) begin
          if (!SER_DATA) r_pend_stop <= 1'b1;
          r_pend_brk <= w_brk_now;
        end
        ST_STOP2: if (RX_tick && !SER_DATA) r_pend_stop <= 1'b1;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------- per-frame result
  // Captured on the final stop tick, so that tick's sample is folded in
  // directly rather than via the pending registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data_out <= '0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_brk      <= 1'b0;
    end else if (w_enter_done) begin
      r_data_out <= r_shift;
      r_par_err  <= r_pend_par;
      r_stop_err <= r_pend_stop | !SER_DATA;
      r_brk      <= (r_state == ST_STOP1) ? w_brk_now : r_pend_brk;
    end
  end

  // ----------------------------------------------------- sticky status
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sticky_par  <= 1'b0;
      r_sticky_stop <= 1'b0;
      r_sticky_brk  <= 1'b0;
    end else begin
      // A new error beats a simultaneous clear.
      if (w_fv && r_par_err)  r_sticky_par  <= 1'b1;
      else if (STS_CLR)       r_sticky_par  <= 1'b0;
      if (w_fv && r_stop_err) r_sticky_stop <= 1'b1;
      else if (STS_CLR)       r_sticky_stop <= 1'b0;
      if (w_fv && r_brk)      r_sticky_brk  <= 1'b1;
      else if (STS_CLR)       r_sticky_brk  <= 1'b0;
    end
  end

  // Breaks are reported separately, so they do not count as stop errors.
  uart_sat_counter #(.CNT_W(CNT_W)) u_par_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (STS_CLR),
    .inc   (w_fv && r_par_err),
    .count (PAR_ERR_CNT)
  );

  uart_sat_counter #(.CNT_W(CNT_W)) u_stop_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (STS_CLR),
    .inc   (w_fv && r_stop_err && !r_brk),
    .count (STOP_ERR_CNT)
  );

  assign DATA_OUT     = r_data_out;
  assign FRAME_VALID  = w_fv;
  assign PARITY_ERROR = r_par_err;
  assign STOP_ERROR   = r_stop_err;
  assign BREAK_DET    = r_brk;
  assign STICKY_PAR   = r_sticky_par;
  assign STICKY_STOP  = r_sticky_stop;
  assign STICKY_BRK   = r_sticky_brk;
  assign BUSY         = (r_state != ST_IDLE);

endmodule : uart_rx_frame_check
`default_nettype wire

// File: tb/tb_uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frame_check
//  Description : Directed self-checking bench. Three instances:
//                u0 DATA_W=8/CNT_W=8, u1 DATA_W=7/CNT_W=8, u2 DATA_W=8/CNT_W=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_frame_check;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic       par_en_s [3];
  logic [1:0] par_mode_s [3];
  logic       stop2_s [3];
  logic       start_s [3];
  logic       tick_s [3];
  logic       ser_s [3];
  logic       clr_s [3];

  logic [7:0] dout0, dout2;
  logic [6:0] dout1;
  logic       fv0, pe0, se0, brk0, sp0, ss0, sb0, busy0;
  logic       fv1, pe1, se1, brk1, sp1, ss1, sb1, busy1;
  logic       fv2, pe2, se2, brk2, sp2, ss2, sb2, busy2;
  logic [7:0] pc0, sc0, pc1, sc1;
  logic [1:0] pc2, sc2;

  uart_rx_frame_check #(.DATA_W(8), .CNT_W(8)) u0 (
    .CLK(CLK), .RST(RST), .CFG_PAR_EN(par_en_s[0]), .CFG_PAR_MODE(par_mode_s[0]),
    .CFG_STOP2(stop2_s[0]), .START(start_s[0]), .RX_tick(tick_s[0]), .SER_DATA(ser_s[0]),
    .STS_CLR(clr_s[0]), .DATA_OUT(dout0), .FRAME_VALID(fv0), .PARITY_ERROR(pe0),
    .STOP_ERROR(se0), .BREAK_DET(brk0), .STICKY_PAR(sp0), .STICKY_STOP(ss0),
    .STICKY_BRK(sb0), .PAR_ERR_CNT(pc0), .STOP_ERR_CNT(sc0), .BUSY(busy0));

  uart_rx_frame_check #(.DATA_W(7), .CNT_W(8)) u1 (
    .CLK(CLK), .RST(RST), .CFG_PAR_EN(par_en_s[1]), .CFG_PAR_MODE(par_mode_s[1]),
    .CFG_STOP2(stop2_s[1]), .START(start_s[1]), .RX_tick(tick_s[1]), .SER_DATA(ser_s[1]),
    .STS_CLR(clr_s[1]), .DATA_OUT(dout1), .FRAME_VALID(fv1), .PARITY_ERROR(pe1),
    .STOP_ERROR(se1), .BREAK_DET(brk1), .STICKY_PAR(sp1), .STICKY_STOP(ss1),
    .STICKY_BRK(sb1), .PAR_ERR_CNT(pc1), .STOP_ERR_CNT(sc1), .BUSY(busy1));

  uart_rx_frame_check #(.DATA_W(8), .CNT_W(2)) u2 (
    .CLK(CLK), .RST(RST), .CFG_PAR_EN(par_en_s[2]), .CFG_PAR_MODE(par_mode_s[2]),
    .CFG_STOP2(stop2_s[2]), .START(start_s[2]), .RX_tick(tick_s[2]), .SER_DATA(ser_s[2]),
    .STS_CLR(clr_s[2]), .DATA_OUT(dout2), .FRAME_VALID(fv2), .PARITY_ERROR(pe2),
    .STOP_ERROR(se2), .BREAK_DET(brk2), .STICKY_PAR(sp2), .STICKY_STOP(ss2),
    .STICKY_BRK(sb2), .PAR_ERR_CNT(pc2), .STOP_ERR_CNT(sc2), .BUSY(busy2));

  int n_checks = 0;
  int n_pass   = 0;
  int fv0_cnt  = 0;

  always @(negedge CLK) if (fv0) fv0_cnt <= fv0_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    cyc();
    start_s[d] = 1'b0;
  endtask

  // Holds the line for a couple of cycles, then one bit-centre tick.
  task automatic send_bit(input int d, input logic b);
    ser_s[d] = b;
    cyc();
    cyc();
    tick_s[d] = 1'b1;
    cyc();
    tick_s[d] = 1'b0;
  endtask

  // Returns 1 ns after the edge that samples the last stop bit (DONE cycle).
  task automatic send_frame(input int d, input int nbits, input logic [8:0] data,
                            input logic has_par, input logic par_bit,
                            input logic stop1, input logic has_stop2, input logic stop2b);
    pulse_start(d);
    for (int i = 0; i < nbits; i++) send_bit(d, data[i]);
    if (has_par) send_bit(d, par_bit);
    send_bit(d, stop1);
    if (has_stop2) send_bit(d, stop2b);
    ser_s[d] = 1'b1;
  endtask

  task automatic set_cfg(input int d, input logic pen, input logic [1:0] pm, input logic s2);
    par_en_s[d]   = pen;
    par_mode_s[d] = pm;
    stop2_s[d]    = s2;
  endtask

  int fv_before;

  initial begin
    for (int d = 0; d < 3; d++) begin
      set_cfg(d, 1'b0, 2'b00, 1'b0);
      start_s[d] = 1'b0;
      tick_s[d]  = 1'b0;
      ser_s[d]   = 1'b1;
      clr_s[d]   = 1'b0;
    end
    RST = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_dout", 32'(dout0), 32'h0);
    chk("rst_fv", 32'(fv0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_pc", 32'(pc0), 32'h0);
    chk("rst_sticky", 32'({sp0, ss0, sb0}), 32'h0);
    RST = 1'b1;
    cyc();

    // 8N1 0xA5, good frame
    set_cfg(0, 1'b0, 2'b00, 1'b0);
    pulse_start(0);
    chk("t1_busy", 32'(busy0), 32'h1);
    for (int i = 0; i < 8; i++) send_bit(0, 1'((8'hA5 >> i) & 8'h01));
    send_bit(0, 1'b1);
    ser_s[0] = 1'b1;
    chk("t1_fv", 32'(fv0), 32'h1);
    chk("t1_dout", 32'(dout0), 32'hA5);
    chk("t1_errs", 32'({pe0, se0, brk0}), 32'h0);
    cyc();
    chk("t1_fv_gone", 32'(fv0), 32'h0);
    chk("t1_idle", 32'(busy0), 32'h0);
    chk("t1_cnts", 32'({pc0, sc0}), 32'h0);
    chk("t1_fvcnt", 32'(fv0_cnt), 32'd1);

    // 8E1 0x07, parity bit 0 (expected 1)
    set_cfg(0, 1'b1, 2'b00, 1'b0);
    send_frame(0, 8, 9'h007, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_fv", 32'(fv0), 32'h1);
    chk("t2_pe", 32'(pe0), 32'h1);
    chk("t2_se", 32'(se0), 32'h0);
    chk("t2_dout", 32'(dout0), 32'h07);
    cyc();
    chk("t2_sp", 32'(sp0), 32'h1);
    chk("t2_pc", 32'(pc0), 32'd1);
    chk("t2_hold_pe", 32'(pe0), 32'h1);

    // 7O2 0x55, good parity (1), stop2 sampled 0
    set_cfg(1, 1'b1, 2'b01, 1'b1);
    send_frame(1, 7, 9'h055, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_fv", 32'(fv1), 32'h1);
    chk("t3_dout", 32'(dout1), 32'h55);
    chk("t3_se", 32'(se1), 32'h1);
    chk("t3_pe", 32'(pe1), 32'h0);
    chk("t3_brk", 32'(brk1), 32'h0);
    cyc();
    chk("t3_sc", 32'(sc1), 32'd1);
    chk("t3_ss", 32'(ss1), 32'h1);

    // 8E1 break: line low for whole frame
    set_cfg(0, 1'b1, 2'b00, 1'b0);
    send_frame(0, 8, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_brk", 32'(brk0), 32'h1);
    chk("t4_se", 32'(se0), 32'h1);
    chk("t4_pe", 32'(pe0), 32'h0);
    cyc();
    chk("t4_sb", 32'(sb0), 32'h1);
    chk("t4_sc", 32'(sc0), 32'd0);
    chk("t4_pc", 32'(pc0), 32'd1);

    // CNT_W=2 saturation, then clear coincident with an error frame
    set_cfg(2, 1'b1, 2'b00, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      send_frame(2, 8, 9'h007, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      chk($sformatf("t5_pc%0d", i), 32'(pc2), (i < 3) ? 32'(i) : 32'd3);
    end
    send_frame(2, 8, 9'h007, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_s[2] = 1'b1;
    cyc();
    clr_s[2] = 1'b0;
    chk("t5_clr_sp", 32'(sp2), 32'h1);
    chk("t5_clr_pc", 32'(pc2), 32'd1);
    clr_s[2] = 1'b1;
    cyc();
    clr_s[2] = 1'b0;
    chk("t5_clr_only", 32'({sp2, pc2}), 32'h0);

    // Reset mid-frame, then a clean 8N1 0x3C
    set_cfg(0, 1'b0, 2'b00, 1'b0);
    fv_before = fv0_cnt;
    pulse_start(0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    RST = 1'b0;
    #1;
    chk("t6_async_busy", 32'(busy0), 32'h0);
    chk("t6_async_dout", 32'(dout0), 32'h0);
    repeat (2) cyc();
    RST = 1'b1;
    repeat (30) cyc();
    chk("t6_no_fv", 32'(fv0_cnt), 32'(fv_before));
    send_frame(0, 8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_fv", 32'(fv0), 32'h1);
    chk("t6_dout", 32'(dout0), 32'h3C);
    chk("t6_errs", 32'({pe0, se0, brk0}), 32'h0);
    cyc();
    chk("t6_fvcnt", 32'(fv0_cnt), 32'(fv_before + 1));
    chk("t6_cnts", 32'({pc0, sc0}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx_frame_check
`default_nettype wire
